data_out_stream_ctrl: RTL and testbench
=======================================

Name: data_out_stream_ctrl

Overview:
Avalon-MM slave that sequences CPU-written bytes onto the 8-bit pixel output toward the convolution filter. It replaces a bare output register with a byte FIFO, a valid/ready handshake and programmable inter-byte pacing. The Nios II pushes bytes and polls status, or takes an interrupt; the filter pulls bytes at its own rate.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2
GAP_W, 8, width of the inter-byte gap counter

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, combinational from address (zero wait states)
out_port  out  8  byte presented to filter (registered)
out_valid  out  1  out_port holds a valid byte
out_ready  in  1  filter accepts byte when high together with out_valid
irq  out  1  level interrupt (see Optional Feature)

Behaviour:
- Write = chipselect & ~write_n. Reads have no side effects. Unused readdata bits are 0.
- Register map:
  - addr 0 DATA: write pushes writedata[7:0]. Read returns out_port.
  - addr 1 STATUS: read returns bit0 empty, bit1 full, bit2 overflow (sticky), bit3 busy (state != IDLE), bits[15:8] FIFO level. Writing 1 to bit2 clears overflow.
  - addr 2 CONTROL: bit0 enable, bit1 irq_en. Bit2 flush is write-only and self-clearing; it reads 0.
  - addr 3 GAP: bits[GAP_W-1:0] give the idle cycles between an accepted byte and the next presentation.
- Reset values: out_port 0, out_valid 0, irq 0, FIFO empty, level 0, overflow 0, enable 0, irq_en 0, GAP 0, state IDLE.
- FIFO push:
  - A push to a full FIFO (registered full flag) is dropped and sets overflow, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves level unchanged.
  - Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.
- Level counts FIFO contents only, not the byte held in out_port.
- State machine IDLE / SEND / GAP:
  - IDLE: if enable and FIFO not empty, load head into out_port, pop, set out_valid, go to SEND. This happens on the same edge.
  - Latency: a write to an empty FIFO with enable=1 in IDLE gives out_valid=1 one cycle after the write edge.
  - SEND: hold out_port and out_valid until out_valid & out_ready.
  - On acceptance with GAP=0: if enable and FIFO not empty, load the next byte on the same edge (back-to-back, 1 byte/cycle). Otherwise clear out_valid and go to IDLE.
  - On acceptance with GAP>0: clear out_valid, load gap counter with GAP, go to GAP.
  - GAP: decrement each cycle. At 1, go to IDLE, which loads the next byte on the following edge. Total spacing is GAP+1 cycles of out_valid low.
- Clearing enable mid-transfer: the presented byte is never retracted. It stays valid until accepted, then the state goes to IDLE and no further loads occur.
- Flush: empties the FIFO, clears out_valid and out_port, and forces IDLE on the next edge, regardless of out_ready. A DATA write in the same cycle as flush is discarded and does not set overflow.
- GAP writes take effect at the next entry to GAP. A running count is unaffected.
- Reset asserted mid-operation returns everything to reset values immediately.

Optional Feature:
DATA_OUT_STREAM_IRQ_EN
- Defined: irq is registered and equals irq_en & empty & (state==IDLE) & ~out_valid. It is updated every cycle; software clears it by refilling or by clearing irq_en.
- Undefined: irq is tied 0, CONTROL bit1 is not stored and reads 0, and no irq logic is present.

Test Plan:
- Reset, then read all addresses → DATA 0; STATUS 0x0000_0001 (empty); CONTROL 0; GAP 0; out_valid 0.
- enable=1, GAP=0, out_ready=1, write 0x11, 0x22, 0x33 on consecutive cycles → out_port 0x11/0x22/0x33 on three consecutive cycles starting one cycle after the first write, then out_valid 0 and busy 0.
- GAP=3, queue 0xA5 and 0x5A, out_ready=1 → 0xA5 accepted, out_valid low for exactly 4 cycles, then 0x5A presented.
- enable=0, write DEPTH+1 bytes → level=DEPTH, full=1, overflow=1; write 0x4 to STATUS → overflow 0; then enable=1 with out_ready=0 → 0x?? first byte held, level DEPTH-1.
- out_valid=1 with out_ready=0, write CONTROL flush → next cycle out_valid 0, level 0, IDLE; a DATA write in the flush cycle is not queued.
- With DATA_OUT_STREAM_IRQ_EN: irq_en=1, drain the last byte → irq rises after final acceptance, falls after the next DATA write. Without the macro: irq stays 0 and CONTROL bit1 reads 0.

Source files
------------

// File: rtl/data_out_stream_ctrl.sv
// Avalon-MM byte streamer: CPU-filled FIFO, valid/ready output with programmable pacing.
// Optional level interrupt enabled by defining DATA_OUT_STREAM_IRQ_EN.
module data_out_stream_ctrl #(
    parameter int DEPTH = 16,
    parameter int GAP_W = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    state_t             state, state_n;
    logic [7:0]         mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [LW-1:0]      level;
    logic               overflow, enable;
    logic [GAP_W-1:0]   gap_reg, gap_cnt;
    logic               irq_en;

    logic wr_en, flush, data_wr, push, load, drop_valid, gap_load;
    logic empty, full, busy;

    assign wr_en   = chipselect & ~write_n;
    assign flush   = wr_en && (address == 2'd2) && writedata[2];
    assign data_wr = wr_en && (address == 2'd0) && !flush;
    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign push    = data_wr && !full;
    assign busy    = (state != ST_IDLE);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_n    = state;
        load       = 1'b0;
        drop_valid = 1'b0;
        gap_load   = 1'b0;
        case (state)
            ST_IDLE: if (enable && !empty) begin
                load    = 1'b1;
                state_n = ST_SEND;
            end
            ST_SEND: if (out_ready) begin
                if (gap_reg == '0) begin
                    if (enable && !empty) begin
                        load = 1'b1;
                    end else begin
                        drop_valid = 1'b1;
                        state_n    = ST_IDLE;
                    end
                end else begin
                    drop_valid = 1'b1;
                    gap_load   = 1'b1;
                    state_n    = ST_GAP;
                end
            end
            ST_GAP: if (gap_cnt <= GAP_W'(1)) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
        // Flush wins over any transfer decision made above.
        if (flush) begin
            state_n    = ST_IDLE;
            load       = 1'b0;
            drop_valid = 1'b1;
            gap_load   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            out_port  <= '0;
            out_valid <= 1'b0;
            gap_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            enable    <= 1'b0;
            gap_reg   <= '0;
        end else begin
            state <= state_n;
            if (flush)     out_port <= '0;
            else if (load) out_port <= mem[rd_ptr];
            if (load)            out_valid <= 1'b1;
            else if (drop_valid) out_valid <= 1'b0;
            if (gap_load)              gap_cnt <= gap_reg;
            else if (state == ST_GAP)  gap_cnt <= gap_cnt - GAP_W'(1);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (load) rd_ptr <= rd_ptr + AW'(1);
                level <= level + LW'(push) - LW'(load);
            end
            if (data_wr && full)
                overflow <= 1'b1;
            else if (wr_en && (address == 2'd1) && writedata[2])
                overflow <= 1'b0;
            if (wr_en && (address == 2'd2)) enable <= writedata[0];
            if (wr_en && (address == 2'd3)) gap_reg <= writedata[GAP_W-1:0];
        end
    end

    // NOTE: the byte storage has no reset; pointers and level define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata[7:0];
    end

`ifdef DATA_OUT_STREAM_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && (address == 2'd2)) irq_en <= writedata[1];
            irq <= irq_en && empty && (state == ST_IDLE) && !out_valid;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[7:0] = out_port;
            2'd1: readdata[15:0] = {8'(level), 4'b0, busy, overflow, full, empty};
            2'd2: readdata[1:0] = {irq_en, enable};
            2'd3: readdata[GAP_W-1:0] = gap_reg;
            default: readdata = '0;
        endcase
    end

    logic unused_wdata;
    assign unused_wdata = ^writedata[31:8];
endmodule

// File: tb/tb_data_out_stream_ctrl.sv
// Self-checking bench for data_out_stream_ctrl: directed register/timing cases plus a
// randomized stream checked against an in-order byte scoreboard.
module tb_data_out_stream_ctrl;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, write_n, out_ready;
    logic [31:0] writedata, readdata, rd;
    logic [7:0]  out_port;
    logic        out_valid, irq;

    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q[$];

    data_out_stream_ctrl #(.DEPTH(DEPTH), .GAP_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .out_valid(out_valid), .out_ready(out_ready), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Scoreboard: every accepted byte must be the oldest byte written and not yet accepted.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("stream_extra_byte", 32'd0, 32'd1);
            else check("stream_byte", {24'd0, out_port}, {24'd0, exp_q.pop_front()});
        end
    end

    initial begin
        int gaps[3];
        int low_cnt;
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; out_ready = 1'b0;
        #22 reset_n = 1'b1;
        tick();

        // Reset state
        rd_reg(2'd0, rd); check("rst_data", rd, 32'h0);
        rd_reg(2'd1, rd); check("rst_status", rd, 32'h1);
        rd_reg(2'd2, rd); check("rst_ctrl", rd, 32'h0);
        rd_reg(2'd3, rd); check("rst_gap", rd, 32'h0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);

        // Back-to-back streaming with GAP=0
        out_ready = 1'b1;
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h11);
        wr(2'd0, 32'h22);
        check("b2b_valid0", {31'd0, out_valid}, 32'd1);
        check("b2b_byte0", {24'd0, out_port}, 32'h11);
        wr(2'd0, 32'h33);
        check("b2b_byte1", {24'd0, out_port}, 32'h22);
        tick();
        check("b2b_byte2", {24'd0, out_port}, 32'h33);
        check("b2b_valid2", {31'd0, out_valid}, 32'd1);
        tick();
        check("b2b_done_valid", {31'd0, out_valid}, 32'd0);
        rd_reg(2'd1, rd); check("b2b_done_status", rd, 32'h1);

        // GAP=3 spacing: four cycles of out_valid low between bytes
        wr(2'd3, 32'h3);
        wr(2'd0, 32'hA5);
        wr(2'd0, 32'h5A);
        check("gap_first", {24'd0, out_port}, 32'hA5);
        low_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) break;
            low_cnt++;
        end
        check("gap_low_cycles", low_cnt, 32'd4);
        check("gap_second", {24'd0, out_port}, 32'h5A);
        for (int i = 0; i < 8; i++) tick();
        wr(2'd3, 32'h0);

        // Overflow with enable off, clear, then re-enable with output stalled
        out_ready = 1'b0;
        wr(2'd2, 32'h0);
        for (int i = 0; i <= DEPTH; i++) wr(2'd0, 32'(i + 1));
        rd_reg(2'd1, rd); check("ovf_status", rd, (32'(DEPTH) << 8) | 32'h6);
        wr(2'd1, 32'h4);
        rd_reg(2'd1, rd); check("ovf_cleared", rd, (32'(DEPTH) << 8) | 32'h2);
        wr(2'd2, 32'h1);
        tick();
        check("held_valid", {31'd0, out_valid}, 32'd1);
        rd_reg(2'd0, rd); check("held_byte", rd, 32'h1);
        rd_reg(2'd1, rd); check("held_status", rd, (32'(DEPTH - 1) << 8) | 32'h8);
        tick();
        check("held_still", {24'd0, out_port}, 32'h1);

        // Flush while a byte is presented and not accepted
        wr(2'd2, 32'h5);
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        rd_reg(2'd1, rd); check("flush_status", rd, 32'h1);
        rd_reg(2'd0, rd); check("flush_data", rd, 32'h0);
        rd_reg(2'd2, rd); check("flush_ctrl", rd, 32'h1);

`ifdef DATA_OUT_STREAM_IRQ_EN
        wr(2'd2, 32'h3);
        tick();
        check("irq_idle_empty", {31'd0, irq}, 32'd1);
        wr(2'd0, 32'h42);
        tick();
        check("irq_after_fill", {31'd0, irq}, 32'd0);
        out_ready = 1'b1;
        tick();
        check("irq_at_accept", {31'd0, irq}, 32'd0);
        tick();
        check("irq_after_drain", {31'd0, irq}, 32'd1);
`else
        wr(2'd2, 32'h3);
        tick();
        check("irq_tied", {31'd0, irq}, 32'd0);
        rd_reg(2'd2, rd); check("irq_en_reads0", rd, 32'h1);
`endif
        wr(2'd2, 32'h1);
        for (int i = 0; i < 4; i++) tick();

        // Randomized streaming against the scoreboard
        wr(2'd2, 32'h5);
        exp_q.delete();
        mon_en = 1'b1;
        gaps[0] = 0; gaps[1] = 1; gaps[2] = $urandom_range(2, 5);
        for (int s = 0; s < 3; s++) begin
            wr(2'd3, 32'(gaps[s]));
            for (int i = 0; i < 300; i++) begin
                out_ready = ($urandom % 4) != 0;
                if (exp_q.size() < DEPTH && ($urandom % 3) != 0) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    address    = 2'd0;
                    writedata  = {24'd0, b};
                    chipselect = 1'b1;
                    write_n    = 1'b0;
                    exp_q.push_back(b);
                end
                tick();
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick();
        check("drain_complete", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        mon_en = 1'b0;
        rd_reg(2'd1, rd); check("final_status", rd, 32'h1);
        check("final_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
